// File: rtl/spi_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_axi_lite_arbiter (with package spi_axi_lite_arbiter_pkg)
// Purpose  : Shares one AXI-Lite master port between NUM_REQ requesters.
//            Requester 0 is the axi_spi_slave bridge; the others are on-chip
//            agents such as a JTAG debug bridge. The write and read directions
//            have independent round-robin arbiters. Each direction allows one
//            outstanding transaction. Payloads pass through combinationally.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - synchronous active-high reset
//            req_i      - requester AXI-Lite requests [NUM_REQ]
//            rsp_o      - requester AXI-Lite responses [NUM_REQ]
//            mst_req_o  - AXI-Lite request toward the crossbar
//            mst_rsp_i  - AXI-Lite response from the crossbar
// Macro    : SPI_ARB_TIMEOUT_EN - enables the response watchdog. On expiry the
//            requester gets SLVERR, and a DRAIN state discards the late response.
// Revision : 1.0 - initial release
// ============================================================================

package spi_axi_lite_arbiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        axi_lite_b_t  b;
        logic         b_valid;
        logic         ar_ready;
        axi_lite_r_t  r;
        logic         r_valid;
    } axi_lite_rsp_t;
endpackage

module spi_axi_lite_arbiter #(
    parameter type         axi_lite_req_t = spi_axi_lite_arbiter_pkg::axi_lite_req_t,
    parameter type         axi_lite_rsp_t = spi_axi_lite_arbiter_pkg::axi_lite_rsp_t,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  axi_lite_req_t req_i [NUM_REQ],
    output axi_lite_rsp_t rsp_o [NUM_REQ],
    output axi_lite_req_t mst_req_o,
    input  axi_lite_rsp_t mst_rsp_i
);

    localparam int unsigned c_IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ADDR  = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [1:0] c_ST_DRAIN = 2'd3;
`endif

    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // First requester with a pending request, scanning upward from ptr with wrap.
    function automatic logic [c_IDX_W-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                                     input logic [c_IDX_W-1:0] ptr);
        logic        found;
        int unsigned idx;
        f_rr_pick = ptr;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[idx]) begin
                f_rr_pick = idx[c_IDX_W-1:0];
                found     = 1'b1;
            end
        end
    endfunction

    function automatic logic [c_IDX_W-1:0] f_next_idx(input logic [c_IDX_W-1:0] idx);
        f_next_idx = (idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // State and arbitration signals
    // ------------------------------------------------------------------------
    logic [1:0]         r_wr_state, w_wr_state_nxt;
    logic [1:0]         r_rd_state, w_rd_state_nxt;
    logic [c_IDX_W-1:0] r_wr_gnt, r_wr_ptr, w_wr_pick;
    logic [c_IDX_W-1:0] r_rd_gnt, r_rd_ptr, w_rd_pick;
    logic               r_aw_done, r_w_done;
    logic [NUM_REQ-1:0] w_aw_valid_vec, w_ar_valid_vec;
    logic               w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic               w_wr_to, w_rd_to;

    always_comb begin
        w_aw_valid_vec = '0;
        w_ar_valid_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_aw_valid_vec[i] = req_i[i].aw_valid;
            w_ar_valid_vec[i] = req_i[i].ar_valid;
        end
    end

    assign w_wr_pick = f_rr_pick(w_aw_valid_vec, r_wr_ptr);
    assign w_rd_pick = f_rr_pick(w_ar_valid_vec, r_rd_ptr);

    // Done flags gate each address/data channel once it has been accepted.
    assign w_aw_hs = (r_wr_state == c_ST_ADDR) && !r_aw_done &&
                     req_i[r_wr_gnt].aw_valid && mst_rsp_i.aw_ready;
    assign w_w_hs  = (r_wr_state == c_ST_ADDR) && !r_w_done &&
                     req_i[r_wr_gnt].w_valid && mst_rsp_i.w_ready;
    assign w_b_hs  = (r_wr_state == c_ST_RESP) && !w_wr_to &&
                     mst_rsp_i.b_valid && req_i[r_wr_gnt].b_ready;
    assign w_ar_hs = (r_rd_state == c_ST_ADDR) &&
                     req_i[r_rd_gnt].ar_valid && mst_rsp_i.ar_ready;
    assign w_r_hs  = (r_rd_state == c_ST_RESP) && !w_rd_to &&
                     mst_rsp_i.r_valid && req_i[r_rd_gnt].r_ready;

    // ------------------------------------------------------------------------
    // Response watchdog
    // ------------------------------------------------------------------------
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned        c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wr_cnt, r_rd_cnt;
    logic               w_wr_err_hs, w_rd_err_hs;

    // Counters restart on every state change, so they count cycles spent in
    // RESP and in DRAIN, and saturate at the last cycle of the window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr_state_nxt != r_wr_state)
                r_wr_cnt <= '0;
            else if (((r_wr_state == c_ST_RESP) || (r_wr_state == c_ST_DRAIN)) &&
                     (r_wr_cnt != c_CNT_LAST))
                r_wr_cnt <= r_wr_cnt + 1'b1;

            if (w_rd_state_nxt != r_rd_state)
                r_rd_cnt <= '0;
            else if (((r_rd_state == c_ST_RESP) || (r_rd_state == c_ST_DRAIN)) &&
                     (r_rd_cnt != c_CNT_LAST))
                r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    // Once the window expires, the error response owns the requester channel.
    // The master channel stays stalled until DRAIN.
    assign w_wr_to     = (r_wr_state == c_ST_RESP) && (r_wr_cnt == c_CNT_LAST);
    assign w_rd_to     = (r_rd_state == c_ST_RESP) && (r_rd_cnt == c_CNT_LAST);
    assign w_wr_err_hs = w_wr_to && req_i[r_wr_gnt].b_ready;
    assign w_rd_err_hs = w_rd_to && req_i[r_rd_gnt].r_ready;
`else
    assign w_wr_to = 1'b0;
    assign w_rd_to = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            c_ST_IDLE: if (|w_aw_valid_vec) w_wr_state_nxt = c_ST_ADDR;
            c_ST_ADDR: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                           w_wr_state_nxt = c_ST_RESP;
            c_ST_RESP: begin
                if (w_b_hs) w_wr_state_nxt = c_ST_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (w_wr_err_hs) w_wr_state_nxt = c_ST_DRAIN;
`endif
            end
`ifdef SPI_ARB_TIMEOUT_EN
            c_ST_DRAIN: if (mst_rsp_i.b_valid || (r_wr_cnt == c_CNT_LAST))
                            w_wr_state_nxt = c_ST_IDLE;
`endif
            default: w_wr_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= c_ST_IDLE;
            r_wr_gnt   <= '0;
            r_wr_ptr   <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if ((r_wr_state == c_ST_IDLE) && |w_aw_valid_vec) begin
                r_wr_gnt  <= w_wr_pick;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            // A timed-out transaction advances the pointer the same as a
            // normal completion.
            if ((r_wr_state == c_ST_RESP) && (w_wr_state_nxt != c_ST_RESP))
                r_wr_ptr <= f_next_idx(r_wr_gnt);
        end
    end

    // ------------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            c_ST_IDLE: if (|w_ar_valid_vec) w_rd_state_nxt = c_ST_ADDR;
            c_ST_ADDR: if (w_ar_hs) w_rd_state_nxt = c_ST_RESP;
            c_ST_RESP: begin
                if (w_r_hs) w_rd_state_nxt = c_ST_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (w_rd_err_hs) w_rd_state_nxt = c_ST_DRAIN;
`endif
            end
`ifdef SPI_ARB_TIMEOUT_EN
            c_ST_DRAIN: if (mst_rsp_i.r_valid || (r_rd_cnt == c_CNT_LAST))
                            w_rd_state_nxt = c_ST_IDLE;
`endif
            default: w_rd_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_state <= c_ST_IDLE;
            r_rd_gnt   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if ((r_rd_state == c_ST_IDLE) && |w_ar_valid_vec)
                r_rd_gnt <= w_rd_pick;
            if ((r_rd_state == c_ST_RESP) && (w_rd_state_nxt != c_ST_RESP))
                r_rd_ptr <= f_next_idx(r_rd_gnt);
        end
    end

    // ------------------------------------------------------------------------
    // Routing. Everything defaults to zero, so non-granted requesters and an
    // idle master port see no valid, ready or payload activity.
    // ------------------------------------------------------------------------
    always_comb begin
        mst_req_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) rsp_o[i] = '0;

        case (r_wr_state)
            c_ST_ADDR: begin
                mst_req_o.aw                = req_i[r_wr_gnt].aw;
                mst_req_o.aw_valid          = req_i[r_wr_gnt].aw_valid & ~r_aw_done;
                mst_req_o.w                 = req_i[r_wr_gnt].w;
                mst_req_o.w_valid           = req_i[r_wr_gnt].w_valid & ~r_w_done;
                rsp_o[r_wr_gnt].aw_ready    = mst_rsp_i.aw_ready & ~r_aw_done;
                rsp_o[r_wr_gnt].w_ready     = mst_rsp_i.w_ready & ~r_w_done;
            end
            c_ST_RESP: begin
                if (w_wr_to) begin
                    rsp_o[r_wr_gnt].b_valid = 1'b1;
                    rsp_o[r_wr_gnt].b.resp  = c_RESP_SLVERR;
                end else begin
                    rsp_o[r_wr_gnt].b       = mst_rsp_i.b;
                    rsp_o[r_wr_gnt].b_valid = mst_rsp_i.b_valid;
                    mst_req_o.b_ready       = req_i[r_wr_gnt].b_ready;
                end
            end
`ifdef SPI_ARB_TIMEOUT_EN
            c_ST_DRAIN: mst_req_o.b_ready = 1'b1;
`endif
            default: ;
        endcase

        case (r_rd_state)
            c_ST_ADDR: begin
                mst_req_o.ar                = req_i[r_rd_gnt].ar;
                mst_req_o.ar_valid          = req_i[r_rd_gnt].ar_valid;
                rsp_o[r_rd_gnt].ar_ready    = mst_rsp_i.ar_ready;
            end
            c_ST_RESP: begin
                if (w_rd_to) begin
                    rsp_o[r_rd_gnt].r_valid = 1'b1;
                    rsp_o[r_rd_gnt].r.resp  = c_RESP_SLVERR;
                end else begin
                    rsp_o[r_rd_gnt].r       = mst_rsp_i.r;
                    rsp_o[r_rd_gnt].r_valid = mst_rsp_i.r_valid;
                    mst_req_o.r_ready       = req_i[r_rd_gnt].r_ready;
                end
            end
`ifdef SPI_ARB_TIMEOUT_EN
            c_ST_DRAIN: mst_req_o.r_ready = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire
